debug_display_scanner: RTL and testbench

- Parametrised successor to the processor's debug display mux. Selects one of NUM_CH DATA_W-bit probe channels for the HEX display bank.
- Adds a registered output, manual and auto-scan modes, a debounced step pushbutton and a freeze/hold capture.
- Sits between the datapath probe taps (PC, IR, RA..RY, RF addresses, ROM, CCR, ...) and the seven-segment driver.

---
 rtl/debug_display_scanner_if.sv | 40 ++++
 rtl/debug_display_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_debug_display_scanner.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_display_scanner_if.sv
// Probe/display bundle for debug_display_scanner. The optional val_changed flag exists only
// when DEBUG_DISPLAY_CHANGE_FLAG_EN is defined.
interface debug_display_scanner_if #(
  parameter int unsigned NUM_CH = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     display_en;
  logic                     auto_mode;
  logic [SEL_W-1:0]         sel_manual;
  logic                     btn_next_n;
  logic                     freeze;
  logic [DATA_W-1:0]        hex_out;
  logic [SEL_W-1:0]         cur_sel;
  logic                     frozen;
`ifdef DEBUG_DISPLAY_CHANGE_FLAG_EN
  logic                     val_changed;

  modport master (
    output ch_data, display_en, auto_mode, sel_manual, btn_next_n, freeze,
    input  hex_out, cur_sel, frozen, val_changed
  );

  modport slave (
    input  ch_data, display_en, auto_mode, sel_manual, btn_next_n, freeze,
    output hex_out, cur_sel, frozen, val_changed
  );
`else
  modport master (
    output ch_data, display_en, auto_mode, sel_manual, btn_next_n, freeze,
    input  hex_out, cur_sel, frozen
  );

  modport slave (
    input  ch_data, display_en, auto_mode, sel_manual, btn_next_n, freeze,
    output hex_out, cur_sel, frozen
  );
`endif
endinterface

// File: rtl/debug_display_scanner.sv
// Selects one of NUM_CH probe words for the HEX display: manual/auto-scan, debounced step button,
// freeze capture. Defining DEBUG_DISPLAY_CHANGE_FLAG_EN adds the val_changed output.
module debug_display_scanner #(
  parameter int unsigned NUM_CH    = 17,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned DWELL     = 50000000,
  parameter int unsigned DEB_CYC   = 500000,
  parameter logic [31:0] BLANK_VAL = 32'h00000FF0,
  parameter logic [31:0] ERR_VAL   = 32'h0000DEDE
) (
  input logic                    clk,
  input logic                    rst_n,
  debug_display_scanner_if.slave bus
);

  localparam int unsigned SelExtW = SEL_W + 1;
  localparam int unsigned DwellW  = $clog2(DWELL);
  localparam int unsigned DebW    = $clog2(DEB_CYC + 1);

  localparam logic [DATA_W-1:0]  BlankWord = DATA_W'(BLANK_VAL);
  localparam logic [DATA_W-1:0]  ErrWord   = DATA_W'(ERR_VAL);
  localparam logic [SelExtW-1:0] NumChExt  = SelExtW'(NUM_CH);
  localparam logic [SEL_W-1:0]   LastCh    = SEL_W'(NUM_CH - 1);
  localparam logic [DwellW-1:0]  DwellLast = DwellW'(DWELL - 1);
  localparam logic [DebW-1:0]    DebLast   = DebW'(DEB_CYC - 1);

  typedef enum logic [1:0] {StBlank, StManual, StAuto, StFrozen} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  hex_q, hex_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]   scan_q, scan_d;
  logic [DwellW-1:0]  dwell_q, dwell_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               pressed_q, pressed_d;
  logic [DebW-1:0]    deb_cnt_q, deb_cnt_d;
  logic               step;
  logic               btn_level;
  logic               manual_in_range;
  logic [SEL_W-1:0]   scan_next;
  logic [DATA_W-1:0]  manual_word;
  logic               frozen;

  // Out-of-range indices match no channel and fall through to the error word.
  function automatic logic [DATA_W-1:0] pick(input logic [NUM_CH*DATA_W-1:0] data,
                                             input logic [SEL_W-1:0]         idx);
    logic [DATA_W-1:0] word;
    word = ErrWord;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (idx == SEL_W'(k)) begin
        word = data[k*DATA_W +: DATA_W];
      end
    end
    return word;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Step button: 2-flop synchroniser, then accept a level only after DEB_CYC stable cycles.
  // ---------------------------------------------------------------------------------------------
  assign btn_level = ~sync2_q;

  always_comb begin
    sync1_d   = bus.btn_next_n;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    deb_cnt_d = '0;
    step      = 1'b0;
    if (btn_level != pressed_q) begin
      if (deb_cnt_q == DebLast) begin
        pressed_d = btn_level;
        step      = btn_level;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBlank;
    end else begin
      state_q <= state_d;
    end
  end

  // Every state shares the same priority: blank, then freeze, then auto/manual.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank, StManual, StAuto, StFrozen: begin
        if (!bus.display_en) begin
          state_d = StBlank;
        end else if (bus.freeze) begin
          state_d = StFrozen;
        end else if (bus.auto_mode) begin
          state_d = StAuto;
        end else begin
          state_d = StManual;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  always_comb begin
    frozen = (state_q == StFrozen);
  end

  // ---------------------------------------------------------------------------------------------
  // Scan index, dwell counter and display register
  // ---------------------------------------------------------------------------------------------
  assign manual_in_range = {1'b0, bus.sel_manual} < NumChExt;
  assign manual_word     = pick(bus.ch_data, bus.sel_manual);
  assign scan_next       = (scan_q == LastCh) ? '0 : scan_q + SEL_W'(1);

  always_comb begin
    scan_d    = scan_q;
    dwell_d   = dwell_q;
    hex_d     = hex_q;
    cur_sel_d = cur_sel_q;
    unique case (state_d)
      StBlank: begin
        hex_d = BlankWord;
      end
      StManual: begin
        cur_sel_d = bus.sel_manual;
        hex_d     = manual_word;
      end
      StAuto: begin
        if (state_q == StManual) begin
          scan_d  = manual_in_range ? bus.sel_manual : '0;
          dwell_d = '0;
        end else if (state_q == StFrozen) begin
          dwell_d = '0;
        end else if (state_q == StAuto) begin
          // A step landing on dwell expiry still advances only once.
          if (step || (dwell_q == DwellLast)) begin
            scan_d  = scan_next;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end
        cur_sel_d = scan_d;
        hex_d     = pick(bus.ch_data, scan_d);
      end
      StFrozen: begin
        hex_d     = hex_q;
        cur_sel_d = cur_sel_q;
      end
      default: begin
        hex_d = BlankWord;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q     <= BlankWord;
      cur_sel_q <= '0;
      scan_q    <= '0;
      dwell_q   <= '0;
    end else begin
      hex_q     <= hex_d;
      cur_sel_q <= cur_sel_d;
      scan_q    <= scan_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.hex_out = hex_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.frozen  = frozen;

`ifdef DEBUG_DISPLAY_CHANGE_FLAG_EN
  logic val_changed_q, val_changed_d;
  logic live_q, live_d;

  // Flags a new value on an unchanged channel, only while the display tracks live data.
  always_comb begin
    live_q        = (state_q == StManual) || (state_q == StAuto);
    live_d        = (state_d == StManual) || (state_d == StAuto);
    val_changed_d = live_q && live_d && (cur_sel_d == cur_sel_q) && (hex_d != hex_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_changed_q <= 1'b0;
    end else begin
      val_changed_q <= val_changed_d;
    end
  end

  assign bus.val_changed = val_changed_q;
`endif

endmodule

// File: tb/tb_debug_display_scanner.sv
// Scoreboard bench for debug_display_scanner: expected display words are queued as stimulus is
// driven and compared after each clock edge.
module tb_debug_display_scanner;

  localparam int unsigned NumCh   = 4;
  localparam int unsigned DataW   = 32;
  localparam int unsigned SelW    = 3;
  localparam int unsigned Dwell   = 4;
  localparam int unsigned DebCyc  = 3;
  // Edges from first sampling the press to the step taking effect: 2 sync flops + debounce.
  localparam int unsigned StepLat = 2 + DebCyc;

  typedef struct packed {
    logic [31:0]     hex;
    logic [SelW-1:0] sel;
    logic            sel_dc;
    logic            frz;
  } exp_t;

  logic          clk;
  logic          rst_n;
  exp_t          exp_q[$];
  int unsigned   nvec;
  int unsigned   nmis;
  logic [31:0]   chv [NumCh];
  int unsigned   m_idx;
  int unsigned   m_cnt;

  debug_display_scanner_if #(.NUM_CH(NumCh), .DATA_W(DataW), .SEL_W(SelW)) bus ();

  debug_display_scanner #(
    .NUM_CH (NumCh),
    .DATA_W (DataW),
    .SEL_W  (SelW),
    .DWELL  (Dwell),
    .DEB_CYC(DebCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no summary, want summary");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ch();
    for (int k = 0; k < NumCh; k++) bus.ch_data[k*DataW +: DataW] = chv[k];
  endtask

  // Reference auto-scan behaviour: advance on dwell expiry or step, never twice.
  task automatic model_auto(input logic stp);
    if (stp || m_cnt == Dwell - 1) begin
      m_idx = (m_idx + 1) % NumCh;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.display_en = 1'b0;
    bus.auto_mode  = 1'b0;
    bus.sel_manual = '0;
    bus.btn_next_n = 1'b1;
    bus.freeze     = 1'b0;
    chv = '{32'h0101, 32'hFFFF, 32'hAAAA, 32'hBBBB};
    load_ch();
    #12;
    nvec++;
    if (bus.hex_out !== 32'h0FF0 || bus.cur_sel !== 3'd0 || bus.frozen !== 1'b0) begin
      nmis++;
      $display("FAIL reset_init: got hex=%h sel=%0d frozen=%b, want hex=00000ff0 sel=0 frozen=0",
               bus.hex_out, bus.cur_sel, bus.frozen);
    end
    @(negedge clk);
    rst_n          = 1'b1;
    bus.display_en = 1'b1;
    bus.sel_manual = 3'd2;
    tick();
    tick();
    nvec++;
    if (bus.hex_out !== 32'hAAAA || bus.cur_sel !== 3'd2) begin
      nmis++;
      $display("FAIL reset_pre: got hex=%h sel=%0d, want hex=0000aaaa sel=2",
               bus.hex_out, bus.cur_sel);
    end
    // Assert reset between edges; outputs must clear with no clock.
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.hex_out !== 32'h0FF0 || bus.cur_sel !== 3'd0 || bus.frozen !== 1'b0) begin
      nmis++;
      $display("FAIL reset_async: got hex=%h sel=%0d frozen=%b, want hex=00000ff0 sel=0 frozen=0",
               bus.hex_out, bus.cur_sel, bus.frozen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual();
    logic [SelW-1:0] sels [5];
    logic [31:0]     want;
    exp_t            e;
    sels = '{3'd2, 3'd7, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        chv[1] = 32'h5555;
        load_ch();
      end
      bus.sel_manual = sels[i];
      if (sels[i] < NumCh) want = chv[sels[i]];
      else                 want = 32'hDEDE;
      exp_q.push_back(exp_t'{hex: want, sel: sels[i], sel_dc: 1'b0, frz: 1'b0});
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel || bus.frozen !== e.frz) begin
        nmis++;
        $display("FAIL manual[%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                 i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
      end
    end
    chv[1] = 32'hFFFF;
    load_ch();
  endtask

  task automatic test_auto_wrap();
    exp_t e;
    bus.sel_manual = 3'd3;
    exp_q.push_back(exp_t'{hex: chv[3], sel: 3'd3, sel_dc: 1'b0, frz: 1'b0});
    tick();
    e = exp_q.pop_front();
    nvec++;
    if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel) begin
      nmis++;
      $display("FAIL auto_pre: got hex=%h sel=%0d, want hex=%h sel=%0d",
               bus.hex_out, bus.cur_sel, e.hex, e.sel);
    end
    bus.auto_mode = 1'b1;
    m_idx = 3;
    m_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) model_auto(1'b0);
      exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel || bus.frozen !== e.frz) begin
        nmis++;
        $display("FAIL auto[%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                 i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
      end
    end
  endtask

  // Presses: 1-clk glitch, 10-clk hold mid-dwell, and a press whose step lands on dwell expiry.
  task automatic test_step();
    int unsigned lens [3];
    int unsigned c0s  [3];
    exp_t        e;
    lens = '{1, 10, 4};
    c0s  = '{0, 1, 3};
    for (int j = 0; j < 3; j++) begin
      while (m_cnt != c0s[j]) begin
        model_auto(1'b0);
        exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
        tick();
        e = exp_q.pop_front();
        nvec++;
        if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel) begin
          nmis++;
          $display("FAIL step_align[%0d]: got hex=%h sel=%0d, want hex=%h sel=%0d",
                   j, bus.hex_out, bus.cur_sel, e.hex, e.sel);
        end
      end
      for (int i = 0; i < int'(lens[j]) + 8; i++) begin
        bus.btn_next_n = (i < int'(lens[j])) ? 1'b0 : 1'b1;
        model_auto(lens[j] >= DebCyc && i == int'(StepLat) - 1);
        exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
        tick();
        e = exp_q.pop_front();
        nvec++;
        if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel || bus.frozen !== e.frz) begin
          nmis++;
          $display("FAIL step[%0d][%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                   j, i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
        end
      end
    end
  endtask

  task automatic test_freeze();
    exp_t e;
    for (int n = 0; n < 16 && m_idx != 1; n++) begin
      model_auto(1'b0);
      exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel) begin
        nmis++;
        $display("FAIL freeze_align: got hex=%h sel=%0d, want hex=%h sel=%0d",
                 bus.hex_out, bus.cur_sel, e.hex, e.sel);
      end
    end
    bus.freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        chv[1] = 32'h1234;
        load_ch();
      end
      exp_q.push_back(exp_t'{hex: 32'hFFFF, sel: 3'd1, sel_dc: 1'b0, frz: 1'b1});
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel || bus.frozen !== e.frz) begin
        nmis++;
        $display("FAIL freeze_hold[%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                 i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
      end
    end
    bus.freeze = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) model_auto(1'b0);
      exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || bus.cur_sel !== e.sel || bus.frozen !== e.frz) begin
        nmis++;
        $display("FAIL freeze_exit[%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                 i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
      end
    end
  endtask

  task automatic test_blank();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       bus.freeze = 1'b1;
        1:       bus.display_en = 1'b0;
        2:       bus.freeze = 1'b0;
        4:       bus.display_en = 1'b1;
        default: ;
      endcase
      if (i == 0) begin
        exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b1});
      end else if (i < 4) begin
        exp_q.push_back(exp_t'{hex: 32'h0FF0, sel: '0, sel_dc: 1'b1, frz: 1'b0});
      end else begin
        exp_q.push_back(exp_t'{hex: chv[m_idx], sel: SelW'(m_idx), sel_dc: 1'b0, frz: 1'b0});
      end
      tick();
      e = exp_q.pop_front();
      nvec++;
      if (bus.hex_out !== e.hex || (!e.sel_dc && bus.cur_sel !== e.sel) ||
          bus.frozen !== e.frz) begin
        nmis++;
        $display("FAIL blank[%0d]: got hex=%h sel=%0d frozen=%b, want hex=%h sel=%0d frozen=%b",
                 i, bus.hex_out, bus.cur_sel, bus.frozen, e.hex, e.sel, e.frz);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    test_reset();
    test_manual();
    test_auto_wrap();
    test_step();
    test_freeze();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
